// File: rtl/wb_arb_nm_1s.sv
// N-master / 1-slave Wishbone arbiter, fixed-priority or round-robin, ownership held for the request window.
// Optional watchdog under `WB_ARB_NM_TIMEOUT_EN: forces an ERR to the owner after TIMEOUT cycles without a slave response.
module wb_arb_nm_1s #(
  parameter int NUM_M    = 4,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int SW       = DW / 8,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic                CLK,
  input  logic                RST_SYNC,
  input  logic                EN,
  input  logic [NUM_M-1:0]    WB_ARB_REQ_IN,
  output logic [NUM_M-1:0]    WB_ARB_GNT_OUT,
  input  logic [NUM_M*AW-1:0] WB_SL_ADR_IN,
  input  logic [NUM_M-1:0]    WB_SL_CYC_IN,
  input  logic [NUM_M-1:0]    WB_SL_STB_IN,
  input  logic [NUM_M-1:0]    WB_SL_WE_IN,
  input  logic [NUM_M*SW-1:0] WB_SL_SEL_IN,
  input  logic [NUM_M*DW-1:0] WB_SL_WR_DAT_IN,
  output logic [NUM_M-1:0]    WB_SL_STALL_OUT,
  output logic [NUM_M-1:0]    WB_SL_ACK_OUT,
  output logic [NUM_M-1:0]    WB_SL_ERR_OUT,
  output logic [DW-1:0]       WB_SL_RD_DAT_OUT,
  output logic [AW-1:0]       WB_M_ADR_OUT,
  output logic                WB_M_CYC_OUT,
  output logic                WB_M_STB_OUT,
  output logic                WB_M_WE_OUT,
  output logic [SW-1:0]       WB_M_SEL_OUT,
  output logic [DW-1:0]       WB_M_WR_DAT_OUT,
  input  logic                WB_M_STALL_IN,
  input  logic                WB_M_ACK_IN,
  input  logic                WB_M_ERR_IN,
  input  logic [DW-1:0]       WB_M_RD_DAT_IN
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t           state;
  logic [NUM_M-1:0] gnt;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    ptr_nxt;
  logic             gnt_any;
  logic             own_cyc;
  logic             to_fire;
  logic             to_mask;

  assign gnt_any        = |gnt;
  assign own_cyc        = WB_SL_CYC_IN[owner];
  assign WB_ARB_GNT_OUT = gnt;

  // Reverse scan so the first candidate in priority order is the one left in win_idx.
  always_comb begin
    int          idx;
    logic [IW-1:0] idx_b;
    win_idx = '0;
    idx     = 0;
    idx_b   = '0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_M - 1; i >= 0; i--) begin
        idx_b = IW'(i);
        if (WB_ARB_REQ_IN[idx_b]) win_idx = idx_b;
      end
    end else begin
      for (int k = NUM_M - 1; k >= 0; k--) begin
        idx   = (int'(ptr) + k) % NUM_M;
        idx_b = IW'(idx);
        if (WB_ARB_REQ_IN[idx_b]) win_idx = idx_b;
      end
    end
  end

  assign ptr_nxt = (win_idx == IW'(NUM_M - 1)) ? '0 : win_idx + IW'(1);

  always_ff @(posedge CLK) begin
    if (RST_SYNC) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      ptr   <= '0;
    end else if (EN) begin
      case (state)
        IDLE: begin
          if (|WB_ARB_REQ_IN) begin
            gnt   <= NUM_M'(1) << win_idx;
            owner <= win_idx;
            if (ARB_MODE != 0) ptr <= ptr_nxt;
            state <= OWNED;
          end
        end
        OWNED: begin
          // Release always passes through IDLE, giving one dead cycle before any re-grant.
          if (!WB_ARB_REQ_IN[owner]) begin
            gnt   <= '0;
            state <= IDLE;
          end
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef WB_ARB_NM_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [TW-1:0] to_cnt;

  assign to_fire = EN && gnt_any && (to_cnt == TW'(TIMEOUT));

  // to_mask swallows a slave response arriving just after the forced error.
  always_ff @(posedge CLK) begin
    if (RST_SYNC) begin
      to_cnt  <= '0;
      to_mask <= 1'b0;
    end else if (EN) begin
      to_mask <= to_fire;
      if (to_fire || !gnt_any || WB_M_ACK_IN || WB_M_ERR_IN)
        to_cnt <= '0;
      else if (own_cyc)
        to_cnt <= to_cnt + TW'(1);
    end
  end
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT;
  assign to_fire        = 1'b0;
  assign to_mask        = 1'b0;
`endif

  assign WB_M_CYC_OUT     = gnt_any && own_cyc && !to_fire;
  assign WB_M_STB_OUT     = gnt_any && WB_SL_STB_IN[owner] && !to_fire;
  assign WB_M_WE_OUT      = gnt_any && WB_SL_WE_IN[owner];
  assign WB_M_ADR_OUT     = gnt_any ? WB_SL_ADR_IN[owner*AW +: AW]    : '0;
  assign WB_M_SEL_OUT     = gnt_any ? WB_SL_SEL_IN[owner*SW +: SW]    : '0;
  assign WB_M_WR_DAT_OUT  = gnt_any ? WB_SL_WR_DAT_IN[owner*DW +: DW] : '0;
  assign WB_SL_RD_DAT_OUT = WB_M_RD_DAT_IN;

  always_comb begin
    WB_SL_STALL_OUT = '1;
    WB_SL_ACK_OUT   = '0;
    WB_SL_ERR_OUT   = '0;
    if (gnt_any) begin
      WB_SL_STALL_OUT[owner] = WB_M_STALL_IN;
      WB_SL_ACK_OUT[owner]   = WB_M_ACK_IN && !to_fire && !to_mask;
      WB_SL_ERR_OUT[owner]   = (WB_M_ERR_IN && !to_mask) || to_fire;
    end
  end

endmodule

// File: tb/tb_wb_arb_nm_1s.sv
// Bench: a fixed-priority and a round-robin instance share stimulus; both are checked every cycle against an ownership model.
module tb_wb_arb_nm_1s;

`ifdef WB_ARB_NM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, en;
  logic [3:0]   req, cyc, stb, we;
  logic [127:0] adr, wdat;
  logic [15:0]  sel;
  logic         s_stall, s_ack, s_err;
  logic [31:0]  s_rdat;

  logic [3:0]   gnt_o [2];
  logic [3:0]   stall_o [2];
  logic [3:0]   ack_o [2];
  logic [3:0]   err_o [2];
  logic [31:0]  rdat_o [2];
  logic [31:0]  madr [2];
  logic [31:0]  mwdat [2];
  logic [3:0]   msel [2];
  logic         mcyc [2];
  logic         mstb [2];
  logic         mwe [2];

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int own [2];
  int ptr [2];
  bit mdl_on = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_arb_nm_1s #(.NUM_M(4), .AW(32), .DW(32), .SW(4), .ARB_MODE(g), .TIMEOUT(8)) u_dut (
      .CLK(clk), .RST_SYNC(rst), .EN(en),
      .WB_ARB_REQ_IN(req), .WB_ARB_GNT_OUT(gnt_o[g]),
      .WB_SL_ADR_IN(adr), .WB_SL_CYC_IN(cyc), .WB_SL_STB_IN(stb), .WB_SL_WE_IN(we),
      .WB_SL_SEL_IN(sel), .WB_SL_WR_DAT_IN(wdat),
      .WB_SL_STALL_OUT(stall_o[g]), .WB_SL_ACK_OUT(ack_o[g]), .WB_SL_ERR_OUT(err_o[g]),
      .WB_SL_RD_DAT_OUT(rdat_o[g]),
      .WB_M_ADR_OUT(madr[g]), .WB_M_CYC_OUT(mcyc[g]), .WB_M_STB_OUT(mstb[g]), .WB_M_WE_OUT(mwe[g]),
      .WB_M_SEL_OUT(msel[g]), .WB_M_WR_DAT_OUT(mwdat[g]),
      .WB_M_STALL_IN(s_stall), .WB_M_ACK_IN(s_ack), .WB_M_ERR_IN(s_err), .WB_M_RD_DAT_IN(s_rdat)
    );
  end

  task automatic chk(input string tag, input int m, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, m, obs, exp);
    end
  endtask

  // Expected outputs follow directly from who owns the bus (or nobody).
  task automatic check_model();
    for (int m = 0; m < 2; m++) begin
      int o;
      logic [3:0] eg, es, ea, ee, esl;
      logic [31:0] ead, ewd;
      logic ec, est, ew;
      o = own[m];
      eg = 4'h0; es = 4'hf; ea = 4'h0; ee = 4'h0; esl = 4'h0;
      ead = 32'h0; ewd = 32'h0; ec = 1'b0; est = 1'b0; ew = 1'b0;
      if (o >= 0) begin
        eg = 4'h1 << o;
        es[o] = s_stall; ea[o] = s_ack; ee[o] = s_err;
        ead = adr[o*32 +: 32]; ewd = wdat[o*32 +: 32]; esl = sel[o*4 +: 4];
        ec = cyc[o]; est = stb[o]; ew = we[o];
      end
      chk("gnt", m, gnt_o[m], eg);
      chk("stall", m, stall_o[m], es);
      chk("ack", m, ack_o[m], ea);
      chk("err", m, err_o[m], ee);
      chk("rd_dat", m, rdat_o[m], s_rdat);
      chk("m_adr", m, madr[m], ead);
      chk("m_wdat", m, mwdat[m], ewd);
      chk("m_sel", m, msel[m], esl);
      chk("m_cyc", m, mcyc[m], ec);
      chk("m_stb", m, mstb[m], est);
      chk("m_we", m, mwe[m], ew);
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int w, i;
      if (rst) begin
        own[m] = -1;
        ptr[m] = 0;
      end else if (en) begin
        if (own[m] >= 0) begin
          if (!req[own[m]]) own[m] = -1;
        end else if (req != 4'h0) begin
          w = -1;
          for (int k = 0; k < 4; k++) begin
            i = (m == 0) ? k : (ptr[m] + k) % 4;
            if (w < 0 && req[i]) w = i;
          end
          own[m] = w;
          if (m == 1) ptr[m] = (w + 1) % 4;
        end
      end
    end
  endtask

  task automatic tick();
    #1;
    if (mdl_on) check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_masters();
    req = 4'h0; cyc = 4'h0; stb = 4'h0; we = 4'h0;
    adr = '0; wdat = '0; sel = '0;
    s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_rdat = 32'h0;
  endtask

  task automatic do_reset();
    clear_masters();
    rst = 1'b1; en = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int order[$];
    int idle_run, idx, fx_seen2, rr_first2, noack;

    clear_masters();
    rst = 1'b1; en = 1'b1;
    tick();
    mdl_on = 1'b1;
    tick();
    for (int m = 0; m < 2; m++) begin
      chk("rst_gnt", m, gnt_o[m], 4'h0);
      chk("rst_stall", m, stall_o[m], 4'hf);
      chk("rst_cyc", m, mcyc[m], 1'b0);
      chk("rst_ack", m, ack_o[m], 4'h0);
    end
    rst = 1'b0;

    // Fixed priority: master1 wins over master3 and its write passes unchanged.
    req = 4'b1010;
    cyc = 4'b1010; stb = 4'b1010; we = 4'b0010;
    adr[32 +: 32] = 32'h100; wdat[32 +: 32] = 32'hDEADBEEF; sel[4 +: 4] = 4'hf;
    adr[96 +: 32] = 32'h300; wdat[96 +: 32] = 32'h33333333;
    tick();
    chk("fx_gnt", 0, gnt_o[0], 4'b0010);
    chk("fx_adr", 0, madr[0], 32'h100);
    chk("fx_wdat", 0, mwdat[0], 32'hDEADBEEF);
    chk("fx_we", 0, mwe[0], 1'b1);
    s_ack = 1'b1;
    tick();
    chk("fx_ack1", 0, ack_o[0][1], 1'b1);
    chk("fx_ack3", 0, ack_o[0][3], 1'b0);
    chk("fx_stall3", 0, stall_o[0][3], 1'b1);
    clear_masters();
    tick();
    tick();

    // Round-robin with every master releasing after one cycle of ownership.
    do_reset();
    req = 4'hf;
    idle_run = 0;
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      tick();
      if (gnt_o[1] != 4'h0) begin
        idx = -1;
        for (int i = 0; i < 4; i++) if (gnt_o[1][i]) idx = i;
        if (order.size() > 0) chk("rr_gap", 1, idle_run, 1);
        order.push_back(idx);
        idle_run = 0;
        req = 4'hf & ~gnt_o[1];
      end else begin
        idle_run++;
        req = 4'hf;
      end
    end
    chk("rr_count", 1, order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++) chk("rr_order", 1, order[i], i % 4);
    clear_masters();
    tick();
    tick();

    // Master0 keeps re-requesting; fixed mode starves master2, round-robin does not.
    do_reset();
    fx_seen2 = 0; rr_first2 = -1;
    for (int c = 0; c < 32; c++) begin
      req = {1'b0, 1'b1, 1'b0, (c % 4) != 3};
      tick();
      if (gnt_o[0][2]) fx_seen2 = 1;
      if (gnt_o[1][2] && rr_first2 < 0) rr_first2 = c;
    end
    chk("fx_starve", 0, fx_seen2, 0);
    chk("rr_no_starve", 1, (rr_first2 >= 0) && (rr_first2 <= 8), 1'b1);
    clear_masters();
    tick();
    tick();

    // Reset in the middle of an owned read, with a late slave ACK.
    do_reset();
    req = 4'b0100;
    tick();
    chk("pre_rst_gnt", 1, gnt_o[1], 4'b0100);
    cyc = 4'b0100; stb = 4'b0100;
    tick();
    chk("pre_rst_cyc", 1, mcyc[1], 1'b1);
    s_ack = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk("mid_rst_gnt", m, gnt_o[m], 4'h0);
      chk("mid_rst_cyc", m, mcyc[m], 1'b0);
      chk("mid_rst_stall", m, stall_o[m], 4'hf);
      chk("mid_rst_ack", m, ack_o[m], 4'h0);
    end
    s_ack = 1'b0; cyc = 4'h0; stb = 4'h0;
    req = 4'b1010;
    tick();
    chk("rr_ptr_reset", 1, gnt_o[1], 4'b0010);
    chk("fx_after_rst", 0, gnt_o[0], 4'b0010);
    clear_masters();
    tick();
    tick();

    // Clock enable low freezes arbitration.
    do_reset();
    en = 1'b0;
    req = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("en0_gnt", 0, gnt_o[0], 4'h0);
    end
    en = 1'b1;
    tick();
    chk("en1_gnt_fx", 0, gnt_o[0], 4'b0010);
    chk("en1_gnt_rr", 1, gnt_o[1], 4'b0010);
    clear_masters();
    tick();
    tick();

    // Slave never responds: a forced error appears only in the watchdog build.
    do_reset();
    mdl_on = !TO_EN;
    req = 4'b0001; cyc = 4'b0001; stb = 4'b0001;
    tick();
    chk("to_cyc_rise", 0, mcyc[0], 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        chk("to_err", m, err_o[m], {3'b000, TO_EN && (k == 8)});
        chk("to_cyc", m, mcyc[m], !(TO_EN && (k == 8)));
        chk("to_ack", m, ack_o[m], 4'h0);
      end
    end
    s_ack = 1'b1;
    tick();
    for (int m = 0; m < 2; m++) chk("to_late_ack", m, ack_o[m], {3'b000, !TO_EN});
    clear_masters();
    tick();
    tick();
    mdl_on = 1'b1;

    // Random traffic against the model; the slave never stays silent long enough to trip the watchdog.
    do_reset();
    noack = 0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) < 3);
      en = ($urandom_range(0, 9) != 0);
      req = req ^ (4'($urandom) & 4'($urandom));
      cyc = 4'($urandom); stb = 4'($urandom); we = 4'($urandom);
      adr = {$urandom, $urandom, $urandom, $urandom};
      wdat = {$urandom, $urandom, $urandom, $urandom};
      sel = 16'($urandom);
      s_stall = 1'($urandom);
      s_err = ($urandom_range(0, 7) == 0);
      s_ack = (noack >= 3) ? 1'b1 : 1'($urandom);
      noack = (s_ack || s_err) ? 0 : noack + 1;
      s_rdat = $urandom;
      tick();
    end
    rst = 1'b0;
    clear_masters();
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
